// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and the data-phase state type used by the
// memory slave and its helpers.
//   HTRANS_*   : transfer type encodings
//   HSIZE_*    : transfer size encodings (2^HSIZE bytes)
//   HRESP_*    : response encodings
//   dp_state_t : data-phase FSM states of ahb_slave_mem_ws
// ---------------------------------------------------------------------------
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      DP_IDLE,
      DP_WAIT,
      DP_LAST,
      DP_ERR1,
      DP_ERR2
   } dp_state_t;

endpackage

// File: rtl/ahb_bytelane_dec.sv
// ---------------------------------------------------------------------------
// ahb_bytelane_dec
// Combinational byte-lane strobe decoder: 2^hsize contiguous lanes starting
// at lane addr_lo. Oversize transfers are rejected upstream, so their strobe
// value is irrelevant.
//   hsize   in  3                 transfer size code
//   addr_lo in  LANE_W            byte offset within the bus word
//   strb    out DATA_WIDTH/8      one bit per byte lane
// ---------------------------------------------------------------------------
module ahb_bytelane_dec #(
   parameter  int DATA_WIDTH = 32,
   localparam int BYTES      = DATA_WIDTH / 8,
   localparam int LANE_W     = $clog2(BYTES)
) (
   input  logic [2:0]        hsize,
   input  logic [LANE_W-1:0] addr_lo,
   output logic [BYTES-1:0]  strb
);

   logic [BYTES-1:0] base;

   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      base = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (i < (1 << hsize)) begin
            base[i] = 1'b1;
         end
      end
      strb = base << addr_lo;
   end

endmodule

// File: rtl/ahb_slave_mem_ws.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem_ws
// AHB-Lite memory slave with byte-lane writes, parameterised wait states,
// write->read forwarding and a two-cycle ERROR response for out-of-range,
// misaligned and oversize transfers.
//   HCLK      in  1           bus clock
//   HRESET    in  1           synchronous active-high reset
//   HSEL      in  1           slave select
//   HADDR     in  ADDR_WIDTH  byte address (top decode bits ignored)
//   HTRANS    in  2           transfer type
//   HWRITE    in  1           1 = write
//   HSIZE     in  3           2^HSIZE bytes
//   HBURST    in  3           unused; every beat carries its own address
//   HWDATA    in  DATA_WIDTH  write data (data phase)
//   HREADY    in  1           bus-level ready
//   HRDATA    out DATA_WIDTH  read data
//   HREADYOUT out 1           slave ready
//   HRESP     out 2           OKAY / ERROR
// ---------------------------------------------------------------------------
module ahb_slave_mem_ws
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_DEPTH   = 16,
   parameter int NO_OF_SLAVES = 4,
   parameter int WAIT_STATES  = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic [1:0]            HRESP
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam int DEC_W  = $clog2(NO_OF_SLAVES);
   localparam int WORD_W = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} >> DEC_W;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM = ADDR_WIDTH'(ADDR_DEPTH);
   // Counter is loaded with WAIT_STATES-1 so DP_WAIT lasts WAIT_STATES cycles.
   localparam logic [3:0]            WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   // ---------------- address-phase decode ----------------
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [ADDR_WIDTH-1:0] size_mask;
   logic [ADDR_WIDTH-1:0] word_idx_full;
   logic                  accept;
   logic                  misaligned;
   logic                  oversize;
   logic                  out_of_range;
   logic                  bad_xfer;
   logic                  good_accept;
   logic [WORD_W-1:0]     acc_word;
   logic [BYTES-1:0]      acc_strb;

   assign addr_a        = HADDR & ADDR_MASK;
   // HTRANS[1] is set exactly for NONSEQ and SEQ.
   assign accept        = HSEL & HREADY & HTRANS[1];
   assign size_mask     = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
   assign misaligned    = |(addr_a & size_mask);
   assign oversize      = (32'd8 << HSIZE) > 32'(DATA_WIDTH);
   assign word_idx_full = addr_a >> LANE_W;
   assign out_of_range  = word_idx_full >= DEPTH_LIM;
   assign bad_xfer      = misaligned | oversize | out_of_range;
   assign good_accept   = accept & ~bad_xfer;
   assign acc_word      = word_idx_full[WORD_W-1:0];

   ahb_bytelane_dec #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_dec (
      .hsize   (HSIZE),
      .addr_lo (addr_a[LANE_W-1:0]),
      .strb    (acc_strb)
   );

   // ---------------- data-phase FSM ----------------
   dp_state_t  state;
   dp_state_t  next_state;
   logic [3:0] wait_cnt;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= DP_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = DP_IDLE;
      HREADYOUT  = 1'b1;
      HRESP      = HRESP_OKAY;

      unique case (state)
         DP_WAIT: HREADYOUT = 1'b0;
         DP_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         DP_ERR2: HRESP = HRESP_ERROR;
         default: ;
      endcase

      if (accept) begin
         if (bad_xfer) begin
            next_state = DP_ERR1;
         end else if (WAIT_STATES > 0) begin
            next_state = DP_WAIT;
         end else begin
            next_state = DP_LAST;
         end
      end else begin
         unique case (state)
            DP_WAIT: next_state = (wait_cnt == 4'd0) ? DP_LAST : DP_WAIT;
            DP_ERR1: next_state = DP_ERR2;
            default: next_state = DP_IDLE;
         endcase
      end
   end

   // ---------------- storage and datapath ----------------
   logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
   logic                  dp_write;
   logic [WORD_W-1:0]     dp_word;
   logic [BYTES-1:0]      dp_strb;
   logic                  wr_en;
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_word;

   // A write lands on the single edge that ends its DP_LAST cycle.
   assign wr_en   = (state == DP_LAST) & dp_write;
   assign fwd_hit = wr_en & (dp_word == acc_word);

   // Merge of the completing write into the word being read.
   always_comb begin
      fwd_word = mem[acc_word];
      for (int i = 0; i < BYTES; i++) begin
         if (dp_strb[i]) begin
            fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_write <= 1'b0;
         dp_word  <= '0;
         dp_strb  <= '0;
         wait_cnt <= '0;
         HRDATA   <= '0;
      end else begin
         if (accept) begin
            // Errored writes are never marked pending, so they cannot reach memory.
            dp_write <= HWRITE & ~bad_xfer;
            dp_word  <= acc_word;
            dp_strb  <= acc_strb;
            wait_cnt <= WS_LOAD;
         end else if ((state == DP_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (good_accept && !HWRITE) begin
            HRDATA <= fwd_hit ? fwd_word : mem[acc_word];
         end
      end
   end

   // NOTE: the memory array has no reset branch; clearing it would need a
   // per-word reset mux and contents are not guaranteed after reset anyway.
   always_ff @(posedge HCLK) begin
      if (!HRESET && wr_en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (dp_strb[i]) begin
               mem[dp_word][8*i +: 8] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{HTRANS[0], HBURST};

endmodule

// File: tb/tb_ahb_slave_mem_ws.sv
module tb_ahb_slave_mem_ws;
   import ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic        use_ws0;

   logic [31:0] rdata_a, rdata_b;
   logic        rdy_a, rdy_b;
   logic [1:0]  resp_a, resp_b;
   logic        hsel_a, hsel_b;

   logic [31:0] obs_rdata;
   logic        obs_rdy;
   logic [1:0]  obs_resp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 HCLK = ~HCLK;

   assign hsel_a    = hsel & ~use_ws0;
   assign hsel_b    = hsel &  use_ws0;
   assign obs_rdata = use_ws0 ? rdata_b : rdata_a;
   assign obs_rdy   = use_ws0 ? rdy_b   : rdy_a;
   assign obs_resp  = use_ws0 ? resp_b  : resp_a;

   ahb_slave_mem_ws #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_DEPTH(16), .NO_OF_SLAVES(4), .WAIT_STATES(2)
   ) dut_ws2 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy_a),
      .HRDATA(rdata_a), .HREADYOUT(rdy_a), .HRESP(resp_a)
   );

   ahb_slave_mem_ws #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_DEPTH(16), .NO_OF_SLAVES(4), .WAIT_STATES(0)
   ) dut_ws0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy_b),
      .HRDATA(rdata_b), .HREADYOUT(rdy_b), .HRESP(resp_b)
   );

   // Single isolated transfer; called #1 after a rising edge with the bus idle.
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic [1:0] resp, output int nwait, output logic [1:0] first_resp);
      logic done;
      done       = 1'b0;
      nwait      = 0;
      rdata      = '0;
      resp       = HRESP_OKAY;
      first_resp = HRESP_OKAY;
      hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = size;
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hwdata = wdata;
      for (int c = 0; c < 20 && !done; c++) begin
         if (obs_rdy === 1'b1) begin
            rdata = obs_rdata;
            resp  = obs_resp;
            done  = 1'b1;
         end else begin
            if (nwait == 0) first_resp = obs_resp;
            nwait++;
         end
         @(posedge HCLK); #1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL xfer_timeout: HREADYOUT stayed low for 20 cycles at addr %h", addr);
      end
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      repeat (2) @(posedge HCLK);
      #1;
      n_checks++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready_ws2: got %b want 1", rdy_a); end
      n_checks++; if (resp_a !== 2'b00) begin n_fail++; $display("FAIL reset_resp_ws2: got %b want 00", resp_a); end
      n_checks++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_ws2: got %h want 0", rdata_a); end
      n_checks++; if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready_ws0: got %b want 1", rdy_b); end
      n_checks++; if (resp_b !== 2'b00) begin n_fail++; $display("FAIL reset_resp_ws0: got %b want 00", resp_b); end
      n_checks++; if (rdata_b !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_ws0: got %h want 0", rdata_b); end
      HRESET = 1'b0;
      @(posedge HCLK); #1;
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; logic [1:0] rs, fr; int nw;
      use_ws0 = 1'b0;
      do_xfer(1'b1, 32'h8, HSIZE_WORD, 32'hDEADBEEF, rd, rs, nw, fr);
      n_checks++; if (nw !== 2) begin n_fail++; $display("FAIL ws_write_waits: got %0d want 2", nw); end
      n_checks++; if (rs !== HRESP_OKAY) begin n_fail++; $display("FAIL ws_write_resp: got %b want 00", rs); end
      do_xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (nw !== 2) begin n_fail++; $display("FAIL ws_read_waits: got %0d want 2", nw); end
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ws_read_data: got %h want deadbeef", rd); end
      n_checks++; if (rs !== HRESP_OKAY) begin n_fail++; $display("FAIL ws_read_resp: got %b want 00", rs); end
      // Top two address bits are the decoder's; they must alias word 2.
      do_xfer(1'b0, 32'hC000_0008, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL decode_bits_ignored: got %h want deadbeef", rd); end
      // Highest in-range word.
      do_xfer(1'b1, 32'h3C, HSIZE_WORD, 32'hA5A5_0F0F, rd, rs, nw, fr);
      do_xfer(1'b0, 32'h3C, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rd !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL last_word_read: got %h want a5a50f0f", rd); end
      n_checks++; if (rs !== HRESP_OKAY) begin n_fail++; $display("FAIL last_word_resp: got %b want 00", rs); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd; logic [1:0] rs, fr; int nw;
      use_ws0 = 1'b0;
      do_xfer(1'b1, 32'h4, HSIZE_WORD, 32'h1122_3344, rd, rs, nw, fr);
      // Only lane 1 may be taken; the other lanes carry garbage.
      do_xfer(1'b1, 32'h5, HSIZE_BYTE, 32'hFFFF_AAFF, rd, rs, nw, fr);
      do_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rd !== 32'h1122_AA44) begin n_fail++; $display("FAIL byte_write_merge: got %h want 1122aa44", rd); end
      do_xfer(1'b1, 32'h6, HSIZE_HALF, 32'hBEEF_0000, rd, rs, nw, fr);
      do_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rd !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL half_write_merge: got %h want beefaa44", rd); end
      do_xfer(1'b1, 32'h3, HSIZE_HALF, 32'h0000_0000, rd, rs, nw, fr);
      n_checks++; if (nw !== 1 || fr !== HRESP_ERROR) begin n_fail++; $display("FAIL misalign_err1: got waits %0d resp %b want 1 01", nw, fr); end
      n_checks++; if (rs !== HRESP_ERROR) begin n_fail++; $display("FAIL misalign_err2: got %b want 01", rs); end
      do_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rd !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL misalign_no_write: got %h want beefaa44", rd); end
   endtask

   task automatic test_error();
      logic [31:0] rd; logic [1:0] rs, fr; int nw;
      use_ws0 = 1'b0;
      // HRDATA currently holds beefaa44 from the previous read.
      do_xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (nw !== 1 || fr !== HRESP_ERROR) begin n_fail++; $display("FAIL range_err1: got waits %0d resp %b want 1 01", nw, fr); end
      n_checks++; if (rs !== HRESP_ERROR) begin n_fail++; $display("FAIL range_err2: got %b want 01", rs); end
      n_checks++; if (rd !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL range_rdata_held: got %h want beefaa44", rd); end
      do_xfer(1'b0, 32'h8, HSIZE_DWORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (nw !== 1 || rs !== HRESP_ERROR) begin n_fail++; $display("FAIL oversize_err: got waits %0d resp %b want 1 01", nw, rs); end
      do_xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rs !== HRESP_OKAY || nw !== 2) begin n_fail++; $display("FAIL after_err_okay: got resp %b waits %0d want 00 2", rs, nw); end
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL after_err_data: got %h want deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic [1:0] rs, fr; int nw;
      use_ws0 = 1'b1;
      do_xfer(1'b1, 32'h0, HSIZE_WORD, 32'h0BAD_F00D, rd, rs, nw, fr);
      // Write 0x12345678 @0, read @0 accepted on the edge the write lands.
      hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0; hwrite = 1'b1; hsize = HSIZE_WORD;
      @(posedge HCLK); #1;
      haddr = 32'h0; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 32'h1234_5678;
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = '0;
      n_checks++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", obs_rdy); end
      n_checks++; if (obs_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_forward_word: got %h want 12345678", obs_rdata); end
      @(posedge HCLK); #1;
      // Byte write @1 forwarded into a word read @0.
      hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h1; hwrite = 1'b1; hsize = HSIZE_BYTE;
      @(posedge HCLK); #1;
      haddr = 32'h0; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 32'hEEEE_77EE;
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = '0;
      n_checks++; if (obs_rdata !== 32'h1234_7778) begin n_fail++; $display("FAIL b2b_forward_byte: got %h want 12347778", obs_rdata); end
      @(posedge HCLK); #1;
      do_xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rd !== 32'h1234_7778 || nw !== 0) begin n_fail++; $display("FAIL b2b_mem_after: got %h waits %0d want 12347778 0", rd, nw); end
   endtask

   task automatic test_reset_mid_transfer();
      logic [31:0] rd; logic [1:0] rs, fr; int nw;
      use_ws0 = 1'b0;
      do_xfer(1'b1, 32'hC, HSIZE_WORD, 32'hCAFE_F00D, rd, rs, nw, fr);
      hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'hC; hwrite = 1'b1; hsize = HSIZE_WORD;
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hwdata = 32'h5555_5555;
      n_checks++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_wait: got %b want 0", obs_rdy); end
      HRESET = 1'b1;
      @(posedge HCLK); #1;
      HRESET = 1'b0; hwdata = '0;
      n_checks++; if (obs_rdy !== 1'b1 || obs_resp !== HRESP_OKAY) begin n_fail++; $display("FAIL rst_mid_outputs: got rdy %b resp %b want 1 00", obs_rdy, obs_resp); end
      n_checks++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", obs_rdata); end
      @(posedge HCLK); #1;
      do_xfer(1'b0, 32'hC, HSIZE_WORD, 32'h0, rd, rs, nw, fr);
      n_checks++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_mid_old_data: got %h want cafef00d", rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      hsize = HSIZE_WORD; hburst = 3'b000; hwdata = '0; use_ws0 = 1'b0;
      test_reset();
      test_wait_states();
      test_byte_lanes();
      test_error();
      test_back_to_back();
      test_reset_mid_transfer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
